dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Sequencer for the MEM stage. It turns the memread/memwrite controls and address/data latched in the EX/MEM pipeline register into a request/grant/response transaction on a variable-latency data-memory port. While the access is outstanding it stalls the pipeline. It then presents load data, and any access fault, to the MEM/WB boundary for exactly one cycle.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles from entering REQ to receiving dm_rvalid before a bus error is declared (2..255).
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_memread  in  1  load pending in EX/MEM.
- mem_memwrite  in  1  store pending in EX/MEM.
- mem_alu_result  in  32  effective byte address.
- mem_rt_data  in  32  store data.
- dm_req  out  1  request valid (registered).
- dm_we  out  1  1 = write, 0 = read; stable while dm_req = 1.
- dm_addr  out  32  word-aligned address; stable while dm_req = 1.
- dm_wdata  out  32  store data; stable while dm_req = 1.
- dm_gnt  in  1  memory accepts the request this cycle.
- dm_rvalid  in  1  response (read data or write acknowledge) this cycle.
- dm_rdata  in  32  read data, valid with dm_rvalid.
- pipe_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
- load_data  out  32  captured read data.
- load_valid  out  1  one-cycle pulse: load_data valid for a completed load.
- exc_misalign  out  1  one-cycle pulse: access address bits [1:0] ≠ 0.
- exc_bus  out  1  one-cycle pulse: access timed out.
- wb_suppress  out  1  one-cycle pulse: the register write of this instruction must be killed.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, with `access = mem_memread | mem_memwrite`:
  - access with aligned address: go to REQ. Latch addr, we = mem_memwrite, and wdata into the dm_* registers.
  - access with misaligned address: go to DONE with the misalign flag set. No bus request is issued.
  - no access: stay in IDLE.
- REQ: dm_req = 1.
  - dm_gnt and dm_rvalid both high: go to DONE.
  - dm_gnt only: go to WAIT.
  - otherwise: stay in REQ.
- WAIT: dm_rvalid goes to DONE. For a read, dm_rdata is captured into load_data.
- Timeout: the counter clears on IDLE→REQ and increments every cycle in REQ or WAIT. When the count reaches TIMEOUT−1 without a response, go to DONE with the bus flag set and drop dm_req.
- DONE lasts one cycle and always returns to IDLE. Outputs in DONE:
  - load_valid = read completed without fault.
  - exc_misalign / exc_bus from their flags.
  - wb_suppress = exc_misalign | exc_bus.
- pipe_stall (combinational) = (IDLE & access) | REQ | WAIT. It is 0 in DONE, so EX/MEM advances on the DONE edge and the same access is never reissued.
- dm_rvalid in IDLE or DONE (stale response) is ignored.
- load_data holds its value until the next captured read. On a fault it is forced to 0.

## Timing
- Reset values: state IDLE, dm_req 0, dm_we 0, dm_addr 0, dm_wdata 0, counter 0, load_data 0, all pulses 0.
- pipe_stall follows mem_memread/mem_memwrite combinationally in IDLE, so it is 1 immediately when an access arrives.
- Best case, aligned access with gnt + rvalid in the first REQ cycle: 2 stall cycles (IDLE, REQ), DONE on the 3rd cycle.
- Each cycle dm_gnt is withheld, and each WAIT cycle, adds one stall cycle.
- Misaligned access: 1 stall cycle (IDLE), then DONE.
- Bus error: DONE occurs TIMEOUT cycles after entering REQ.
- rst_n low mid-access: dm_req drops asynchronously and the FSM returns to IDLE. Any later response is discarded.

## Structure
- The shared package holds:
  - the state enum, 2-bit, IDLE = 0, REQ = 1, WAIT = 2, DONE = 3;
  - the default TIMEOUT constant;
  - the misaligned-mask constant 2'b00.
- One sub-module, `access_timer`: a CNT_W counter with clear/enable and an `expired` output. It isolates the timeout logic for reuse by the instruction-fetch controller.

## Test plan
- Load, addr 0x100, gnt + rvalid same cycle as REQ, rdata 0xDEADBEEF → pipe_stall high 2 cycles; DONE shows load_valid = 1 and load_data = 0xDEADBEEF.
- Store, addr 0x204, wdata 0x12345678, gnt after 3 cycles, rvalid 2 cycles later → dm_req high 4 cycles with dm_we = 1 and stable addr/data; pipe_stall high 7 cycles; load_valid = 0.
- Load, addr 0x102 → no dm_req; exc_misalign and wb_suppress pulse 1 cycle after arrival; pipe_stall 1 cycle.
- Load with no dm_gnt, TIMEOUT = 16 → exc_bus pulse at cycle 16 after REQ entry; load_data = 0; dm_req low in DONE.
- Back-to-back loads at 0x10 and 0x14 → two distinct transactions, each with its own DONE, and no reissue of the first.
- rst_n asserted during WAIT, then a late dm_rvalid → dm_req 0, IDLE, no load_valid pulse.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl_pkg
// Shared types and constants for the MEM-stage data-memory sequencer and its
// timeout counter.
//   state_e         : sequencer states (2-bit encoding)
//   TIMEOUT_DEFAULT : default response timeout in cycles
//   ALIGN_OK        : required value of address bits [1:0] for a word access
//   is_misaligned() : helper flagging a non-word-aligned byte address
// ---------------------------------------------------------------------------
package dmem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int         TIMEOUT_DEFAULT = 16;
    localparam logic [1:0] ALIGN_OK        = 2'b00;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != ALIGN_OK;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_timer.sv
// ---------------------------------------------------------------------------
// access_timer
// Cycle counter used to bound how long a memory access may stay outstanding.
// Shared with the instruction-fetch controller.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count up by one this cycle
//   expired    : count has reached TIMEOUT-1 (last allowed cycle)
// ---------------------------------------------------------------------------
module access_timer #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

    // The cycle holding TIMEOUT-1 is the last one a response may arrive in.
    assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_access_ctrl
// MEM-stage sequencer: turns memread/memwrite from EX/MEM into a req/gnt/
// rvalid transaction on a variable-latency data-memory port, stalls the
// pipeline while it is outstanding, then presents load data and faults to
// MEM/WB for exactly one cycle (the DONE state).
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   mem_memread, mem_memwrite       : access pending in EX/MEM
//   mem_alu_result, mem_rt_data     : byte address, store data
//   dm_req/dm_we/dm_addr/dm_wdata   : registered request, stable while dm_req
//   dm_gnt, dm_rvalid, dm_rdata     : grant, response, read data
//   pipe_stall                      : freeze upstream pipeline this cycle
//   load_data, load_valid           : captured read data, 1-cycle valid pulse
//   exc_misalign, exc_bus           : 1-cycle fault pulses
//   wb_suppress                     : 1-cycle pulse killing the register write
// ---------------------------------------------------------------------------
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_memread,
    input  logic        mem_memwrite,
    input  logic [31:0] mem_alu_result,
    input  logic [31:0] mem_rt_data,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        pipe_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        exc_misalign,
    output logic        exc_bus,
    output logic        wb_suppress
);

    state_e state_q, state_d;
    logic   access, misaligned;
    logic   tmr_clr, tmr_en, tmr_expired;
    logic   resp, timeout_hit;
    logic   mis_q, bus_q;

    assign access     = mem_memread | mem_memwrite;
    assign misaligned = is_misaligned(mem_alu_result);

    access_timer #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expired(tmr_expired)
    );

    // A response only counts while the access is actually outstanding; a
    // stale rvalid in IDLE or DONE falls through untouched.
    assign resp        = ((state_q == REQ) && dm_gnt && dm_rvalid) ||
                         ((state_q == WAIT) && dm_rvalid);
    assign timeout_hit = ((state_q == REQ) || (state_q == WAIT)) &&
                         tmr_expired && !resp;

    always_comb begin
        state_d = state_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = misaligned ? DONE : REQ;
                    tmr_clr = !misaligned;
                end
            end
            REQ: begin
                tmr_en = 1'b1;
                if (resp || timeout_hit) state_d = DONE;
                else if (dm_gnt)         state_d = WAIT;
            end
            WAIT: begin
                tmr_en = 1'b1;
                if (resp || timeout_hit) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            load_data <= '0;
            mis_q     <= 1'b0;
            bus_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            // Registered so dm_req is high exactly while the FSM sits in REQ.
            dm_req  <= (state_d == REQ);
            if ((state_q == IDLE) && access) begin
                mis_q <= misaligned;
                bus_q <= 1'b0;
                if (misaligned) begin
                    load_data <= '0;
                end else begin
                    dm_we    <= mem_memwrite;
                    dm_addr  <= {mem_alu_result[31:2], 2'b00};
                    dm_wdata <= mem_rt_data;
                end
            end
            if (resp && !dm_we)
                load_data <= dm_rdata;
            if (timeout_hit) begin
                bus_q     <= 1'b1;
                load_data <= '0;
            end
        end
    end

    // DONE-cycle outputs; dm_we still describes the access that just ended.
    assign exc_misalign = (state_q == DONE) && mis_q;
    assign exc_bus      = (state_q == DONE) && bus_q;
    assign wb_suppress  = exc_misalign | exc_bus;
    assign load_valid   = (state_q == DONE) && !dm_we && !mis_q && !bus_q;

    // Stall is 0 in DONE so EX/MEM advances and the access is not reissued.
    assign pipe_stall = ((state_q == IDLE) && access) ||
                        (state_q == REQ) || (state_q == WAIT);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_memread, mem_memwrite;
    logic [31:0] mem_alu_result, mem_rt_data;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        pipe_stall;
    logic [31:0] load_data;
    logic        load_valid, exc_misalign, exc_bus, wb_suppress;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_memread   (mem_memread),
        .mem_memwrite  (mem_memwrite),
        .mem_alu_result(mem_alu_result),
        .mem_rt_data   (mem_rt_data),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_gnt        (dm_gnt),
        .dm_rvalid     (dm_rvalid),
        .dm_rdata      (dm_rdata),
        .pipe_stall    (pipe_stall),
        .load_data     (load_data),
        .load_valid    (load_valid),
        .exc_misalign  (exc_misalign),
        .exc_bus       (exc_bus),
        .wb_suppress   (wb_suppress)
    );

    typedef struct {
        int          stall;
        int          req;
        logic        done;
        logic        stable;
        logic        req_done;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        lv;
        logic [31:0] ld;
        logic        mis;
        logic        bus;
        logic        wbs;
    } res_t;

    res_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Memory responder + observer for one access. Grants after gnt_wait
    // withheld REQ cycles, responds rv_gap cycles after the grant (0 = same
    // cycle). Returns what was seen up to and including the DONE cycle.
    task automatic drive_access(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int gnt_wait,
                                input int rv_gap, input bit no_gnt, output res_t o);
        int cyc = 0, req_n = 0, gap = 0;
        bit granted = 0;
        o = '{default: 0};
        o.stable = 1'b1;
        while (!o.done && cyc < 64) begin
            @(negedge clk);
            if (cyc == 0) begin
                mem_memread = rd; mem_memwrite = wr;
                mem_alu_result = addr; mem_rt_data = wdata;
            end
            cyc++;
            dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
            if (dm_req) begin
                if (req_n == 0) begin
                    o.we = dm_we; o.addr = dm_addr; o.wdata = dm_wdata;
                end else if (dm_we !== o.we || dm_addr !== o.addr || dm_wdata !== o.wdata) begin
                    o.stable = 1'b0;
                end
                req_n++;
                if (!no_gnt && req_n > gnt_wait) begin
                    dm_gnt = 1'b1; granted = 1;
                    if (rv_gap == 0) begin dm_rvalid = 1'b1; dm_rdata = rdata; end
                end
            end else if (granted) begin
                gap++;
                if (gap == rv_gap) begin dm_rvalid = 1'b1; dm_rdata = rdata; end
            end
            #1;
            if (pipe_stall) o.stall++;
            else if (o.stall > 0) begin
                o.done = 1'b1; o.req_done = dm_req;
                o.lv = load_valid; o.ld = load_data;
                o.mis = exc_misalign; o.bus = exc_bus; o.wbs = wb_suppress;
            end
        end
        o.req = req_n;
    endtask

    // Quiet cycles: no access, no bus activity. Counts any request or pulse.
    task automatic idle(input int n, output int req_hits, output int pulses);
        req_hits = 0; pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_memread = 1'b0; mem_memwrite = 1'b0;
            dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
            #1;
            if (dm_req) req_hits++;
            if (load_valid | exc_misalign | exc_bus | wb_suppress) pulses++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        mem_memread = 1'b0; mem_memwrite = 1'b0; mem_alu_result = '0; mem_rt_data = '0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_checks++; if ({dm_req, dm_we, pipe_stall} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got req/we/stall=%b%b%b exp 000", dm_req, dm_we, pipe_stall); end
        n_checks++; if (dm_addr !== 32'h0 || dm_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_bus got addr=%h wdata=%h exp 0", dm_addr, dm_wdata); end
        n_checks++; if (load_data !== 32'h0) begin n_fail++; $display("FAIL reset_ld got %h exp 0", load_data); end
        n_checks++; if ({load_valid, exc_misalign, exc_bus, wb_suppress} !== 4'b0) begin n_fail++; $display("FAIL reset_pulses got %b%b%b%b exp 0000", load_valid, exc_misalign, exc_bus, wb_suppress); end
    endtask

    task automatic test_load_fast;
        res_t e, o;
        int rq, pl;
        e = '{default: 0};
        e.stall = 2; e.req = 1; e.done = 1; e.addr = 32'h100; e.lv = 1; e.ld = 32'hDEADBEEF;
        sb_q.push_back(e);
        drive_access(1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, o);
        e = sb_q.pop_front();
        n_checks++; if (o.done !== e.done) begin n_fail++; $display("FAIL fast_done got %b exp %b", o.done, e.done); end
        n_checks++; if (o.stall !== e.stall) begin n_fail++; $display("FAIL fast_stall got %0d exp %0d", o.stall, e.stall); end
        n_checks++; if (o.req !== e.req || o.we !== 1'b0 || o.addr !== e.addr) begin n_fail++; $display("FAIL fast_req got n=%0d we=%b addr=%h exp n=%0d we=0 addr=%h", o.req, o.we, o.addr, e.req, e.addr); end
        n_checks++; if (o.lv !== e.lv || o.ld !== e.ld) begin n_fail++; $display("FAIL fast_load got lv=%b ld=%h exp lv=%b ld=%h", o.lv, o.ld, e.lv, e.ld); end
        n_checks++; if ({o.mis, o.bus, o.wbs} !== 3'b000) begin n_fail++; $display("FAIL fast_exc got %b%b%b exp 000", o.mis, o.bus, o.wbs); end
        idle(2, rq, pl);
        n_checks++; if (pl !== 0 || rq !== 0) begin n_fail++; $display("FAIL fast_after got pulses=%0d reqs=%0d exp 0 0", pl, rq); end
    endtask

    task automatic test_store_wait;
        res_t e, o;
        int rq, pl;
        e = '{default: 0};
        e.stall = 7; e.req = 4; e.done = 1; e.stable = 1; e.we = 1;
        e.addr = 32'h204; e.wdata = 32'h12345678; e.lv = 0; e.ld = 32'hDEADBEEF;
        sb_q.push_back(e);
        drive_access(0, 1, 32'h204, 32'h12345678, 32'h0, 3, 2, 0, o);
        e = sb_q.pop_front();
        n_checks++; if (o.req !== e.req) begin n_fail++; $display("FAIL store_req_cycles got %0d exp %0d", o.req, e.req); end
        n_checks++; if (o.stall !== e.stall) begin n_fail++; $display("FAIL store_stall got %0d exp %0d", o.stall, e.stall); end
        n_checks++; if (o.we !== e.we || o.addr !== e.addr || o.wdata !== e.wdata) begin n_fail++; $display("FAIL store_bus got we=%b addr=%h wd=%h exp we=%b addr=%h wd=%h", o.we, o.addr, o.wdata, e.we, e.addr, e.wdata); end
        n_checks++; if (o.stable !== e.stable) begin n_fail++; $display("FAIL store_stable got %b exp %b", o.stable, e.stable); end
        n_checks++; if (o.lv !== e.lv || o.ld !== e.ld) begin n_fail++; $display("FAIL store_load got lv=%b ld=%h exp lv=%b ld=%h", o.lv, o.ld, e.lv, e.ld); end
        n_checks++; if ({o.mis, o.bus, o.wbs} !== 3'b000) begin n_fail++; $display("FAIL store_exc got %b%b%b exp 000", o.mis, o.bus, o.wbs); end
        idle(2, rq, pl);
    endtask

    task automatic test_misalign;
        res_t e, o;
        int rq, pl;
        e = '{default: 0};
        e.stall = 1; e.req = 0; e.done = 1; e.mis = 1; e.wbs = 1; e.ld = 32'h0;
        sb_q.push_back(e);
        drive_access(1, 0, 32'h102, 32'h0, 32'hFFFFFFFF, 0, 0, 0, o);
        e = sb_q.pop_front();
        n_checks++; if (o.req !== e.req || o.req_done !== 1'b0) begin n_fail++; $display("FAIL mis_noreq got n=%0d req_done=%b exp 0 0", o.req, o.req_done); end
        n_checks++; if (o.stall !== e.stall) begin n_fail++; $display("FAIL mis_stall got %0d exp %0d", o.stall, e.stall); end
        n_checks++; if ({o.mis, o.bus, o.wbs, o.lv} !== {e.mis, e.bus, e.wbs, e.lv}) begin n_fail++; $display("FAIL mis_flags got mis/bus/wbs/lv=%b%b%b%b exp %b%b%b%b", o.mis, o.bus, o.wbs, o.lv, e.mis, e.bus, e.wbs, e.lv); end
        n_checks++; if (o.ld !== e.ld) begin n_fail++; $display("FAIL mis_ld got %h exp %h", o.ld, e.ld); end
        idle(2, rq, pl);
        n_checks++; if (pl !== 0 || rq !== 0) begin n_fail++; $display("FAIL mis_pulse_len got pulses=%0d reqs=%0d exp 0 0", pl, rq); end
    endtask

    task automatic test_back_to_back;
        res_t e, o1, o2;
        int rq, pl;
        e = '{default: 0};
        e.stall = 3; e.req = 1; e.done = 1; e.addr = 32'h10; e.lv = 1; e.ld = 32'hAAAA0010;
        sb_q.push_back(e);
        e.stall = 3; e.req = 2; e.addr = 32'h14; e.ld = 32'h55550014;
        sb_q.push_back(e);
        drive_access(1, 0, 32'h10, 32'h0, 32'hAAAA0010, 0, 1, 0, o1);
        drive_access(1, 0, 32'h14, 32'h0, 32'h55550014, 1, 0, 0, o2);
        e = sb_q.pop_front();
        n_checks++; if (o1.stall !== e.stall || o1.req !== e.req || o1.addr !== e.addr) begin n_fail++; $display("FAIL b2b_first got stall=%0d req=%0d addr=%h exp %0d %0d %h", o1.stall, o1.req, o1.addr, e.stall, e.req, e.addr); end
        n_checks++; if (o1.lv !== e.lv || o1.ld !== e.ld) begin n_fail++; $display("FAIL b2b_first_load got lv=%b ld=%h exp lv=%b ld=%h", o1.lv, o1.ld, e.lv, e.ld); end
        e = sb_q.pop_front();
        n_checks++; if (o2.stall !== e.stall || o2.req !== e.req || o2.addr !== e.addr) begin n_fail++; $display("FAIL b2b_second got stall=%0d req=%0d addr=%h exp %0d %0d %h", o2.stall, o2.req, o2.addr, e.stall, e.req, e.addr); end
        n_checks++; if (o2.lv !== e.lv || o2.ld !== e.ld) begin n_fail++; $display("FAIL b2b_second_load got lv=%b ld=%h exp lv=%b ld=%h", o2.lv, o2.ld, e.lv, e.ld); end
        idle(3, rq, pl);
        n_checks++; if (rq !== 0 || pl !== 0) begin n_fail++; $display("FAIL b2b_reissue got reqs=%0d pulses=%0d exp 0 0", rq, pl); end
    endtask

    task automatic test_timeout;
        res_t e, o;
        int rq, pl;
        e = '{default: 0};
        e.stall = TO + 1; e.req = TO; e.done = 1; e.bus = 1; e.wbs = 1; e.ld = 32'h0;
        sb_q.push_back(e);
        drive_access(1, 0, 32'h300, 32'h0, 32'h0, 0, 0, 1, o);
        e = sb_q.pop_front();
        n_checks++; if (o.done !== e.done) begin n_fail++; $display("FAIL to_done got %b exp %b", o.done, e.done); end
        n_checks++; if (o.req !== e.req) begin n_fail++; $display("FAIL to_req_cycles got %0d exp %0d", o.req, e.req); end
        n_checks++; if (o.stall !== e.stall) begin n_fail++; $display("FAIL to_stall got %0d exp %0d", o.stall, e.stall); end
        n_checks++; if ({o.bus, o.wbs, o.mis, o.lv} !== {e.bus, e.wbs, e.mis, e.lv}) begin n_fail++; $display("FAIL to_flags got bus/wbs/mis/lv=%b%b%b%b exp %b%b%b%b", o.bus, o.wbs, o.mis, o.lv, e.bus, e.wbs, e.mis, e.lv); end
        n_checks++; if (o.ld !== e.ld || o.req_done !== 1'b0) begin n_fail++; $display("FAIL to_ld_req got ld=%h req=%b exp 0 0", o.ld, o.req_done); end
        idle(2, rq, pl);
    endtask

    task automatic test_reset_mid_wait;
        int rq, pl;
        @(negedge clk);
        mem_memread = 1'b1; mem_memwrite = 1'b0; mem_alu_result = 32'h40;
        dm_gnt = 1'b0; dm_rvalid = 1'b0;
        @(negedge clk);
        n_checks++; if (dm_req !== 1'b1) begin n_fail++; $display("FAIL rst_req_up got %b exp 1", dm_req); end
        dm_gnt = 1'b1;
        @(negedge clk);
        dm_gnt = 1'b0;
        n_checks++; if (dm_req !== 1'b0 || pipe_stall !== 1'b1) begin n_fail++; $display("FAIL rst_in_wait got req=%b stall=%b exp 0 1", dm_req, pipe_stall); end
        #2 rst_n = 1'b0; mem_memread = 1'b0;
        #1;
        n_checks++; if (dm_req !== 1'b0 || pipe_stall !== 1'b0) begin n_fail++; $display("FAIL rst_async got req=%b stall=%b exp 0 0", dm_req, pipe_stall); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dm_rvalid = 1'b1; dm_rdata = 32'hBAD0BAD0;
        #1;
        n_checks++; if (load_valid !== 1'b0 || pipe_stall !== 1'b0) begin n_fail++; $display("FAIL rst_late_rvalid got lv=%b stall=%b exp 0 0", load_valid, pipe_stall); end
        idle(3, rq, pl);
        n_checks++; if (rq !== 0 || pl !== 0 || load_data !== 32'h0) begin n_fail++; $display("FAIL rst_after got reqs=%0d pulses=%0d ld=%h exp 0 0 0", rq, pl, load_data); end
    endtask

    initial begin
        test_reset();
        test_load_fast();
        test_store_wait();
        test_misalign();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached got running exp finished");
        $fatal(1);
    end

endmodule
